// File: rtl/pc_redirect_unit.sv
// IF-stage program counter with EX-resolved redirects, memory-wait holding and squash control.
// Redirects that arrive during an instruction-memory wait are parked until memory releases.
module pc_redirect_unit #(
  parameter logic [31:0] ResetPc  = 32'h0000_0000,
  parameter int unsigned CntWidth = 16
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                pc_sel_i,
  input  logic                ex_valid_i,
  input  logic [31:0]         branch_target_i,
  input  logic                stall_i,
  input  logic                imem_busywait_i,
  output logic [31:0]         pc_o,
  output logic [31:0]         pc_plus4_o,
  output logic                imem_read_o,
  output logic                flush_o,
  output logic                misalign_o,
  output logic [CntWidth-1:0] redirect_count_o
);

  typedef enum logic [1:0] {
    StBoot,
    StRun,
    StPend
  } state_e;

  state_e              state_q, state_d;
  logic [31:0]         pc_q, pc_d;
  logic [31:0]         pend_q, pend_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic                mis_q, mis_d;
  logic                imem_read_q;

  logic        redir;
  logic        redir_taken;
  logic [31:0] target_aligned;

  assign redir          = pc_sel_i & ex_valid_i;
  // Redirects seen while booting are dropped entirely.
  assign redir_taken    = redir & (state_q != StBoot);
  assign target_aligned = {branch_target_i[31:2], 2'b00};

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    pend_d  = pend_q;
    flush_o = 1'b0;
    unique case (state_q)
      StBoot: begin
        state_d = StRun;
      end
      StRun: begin
        if (redir) begin
          flush_o = 1'b1;
          if (imem_busywait_i) begin
            pend_d  = target_aligned;
            state_d = StPend;
          end else begin
            pc_d = target_aligned;
          end
        end else if (!imem_busywait_i && !stall_i) begin
          pc_d = pc_q + 32'd4;
        end
      end
      StPend: begin
        if (redir) begin
          flush_o = 1'b1;
          pend_d  = target_aligned;
        end
        // On release the word memory returns belongs to the old path, so squash it.
        if (!imem_busywait_i) begin
          flush_o = 1'b1;
          pc_d    = redir ? target_aligned : pend_q;
          state_d = StRun;
        end
      end
      default: begin
        state_d = StBoot;
      end
    endcase
    if (reset_i) begin
      flush_o = 1'b0;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (redir_taken && (cnt_q != {CntWidth{1'b1}})) begin
      cnt_d = cnt_q + CntWidth'(1);
    end
    mis_d = mis_q | (redir_taken & (branch_target_i[1:0] != 2'b00));
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= StBoot;
      pc_q        <= ResetPc;
      pend_q      <= 32'h0000_0000;
      cnt_q       <= '0;
      mis_q       <= 1'b0;
      imem_read_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      pend_q      <= pend_d;
      cnt_q       <= cnt_d;
      mis_q       <= mis_d;
      imem_read_q <= (state_d != StBoot);
    end
  end

  assign pc_o             = pc_q;
  assign pc_plus4_o       = pc_q + 32'd4;
  assign imem_read_o      = imem_read_q;
  assign misalign_o       = mis_q;
  assign redirect_count_o = cnt_q;

endmodule

// File: doc/pc_redirect_unit.md
# pc_redirect_unit

Program-counter and redirect controller for the IF stage of the RV32IM pipeline. It consumes the taken/not-taken decision (PC_SEL) and branch/jump target resolved in EX. It owns the PC register and drives the instruction-memory read request. It generates the squash pulses for the IF/ID and ID/EX pipeline registers, and arbitrates redirects against hazard stalls and instruction-memory wait states.

## Interface
- RESET_PC, default 32'h0000_0000: PC value loaded on reset.
- CNT_WIDTH, default 16: width of the saturating redirect counter.

- CLK  in  1  clock; all state updates on rising edge.
- RESET  in  1  synchronous, active-high reset.
- PC_SEL  in  1  redirect request from EX-stage branch logic.
- EX_VALID  in  1  EX-stage instruction is valid. PC_SEL is ignored when 0.
- BRANCH_TARGET  in  32  redirect address from the EX-stage ALU.
- STALL  in  1  load-use stall from the hazard unit; hold PC.
- IMEM_BUSYWAIT  in  1  instruction memory not ready; hold PC.
- PC  out  32  current fetch address (registered).
- PC_PLUS4  out  32  PC + 4, mod 2^32, combinational.
- IMEM_READ  out  1  fetch request.
- FLUSH  out  1  squash IF/ID and ID/EX contents at this edge.
- MISALIGN  out  1  sticky: a redirect target had bits [1:0] != 0.
- REDIRECT_COUNT  out  CNT_WIDTH  number of taken redirects, saturating.

## Operation
- The redirect condition is REDIR = PC_SEL & EX_VALID.
- States: S_BOOT, S_RUN, S_PEND.
- RESET (any state): go to S_BOOT.
  - PC = RESET_PC, FLUSH = 0, MISALIGN = 0, REDIRECT_COUNT = 0.
  - Pending-target register = 0.
- S_BOOT lasts exactly one cycle with IMEM_READ = 0, then goes to S_RUN. PC is unchanged.
- S_RUN: IMEM_READ = 1. Priority is REDIR > IMEM_BUSYWAIT > STALL > increment.
  - REDIR & !IMEM_BUSYWAIT: PC <= {BRANCH_TARGET[31:2], 2'b00}; FLUSH = 1 this cycle.
  - REDIR & IMEM_BUSYWAIT:
    - Latch the aligned target into the pending register.
    - FLUSH = 1 this cycle.
    - Go to S_PEND. PC holds.
  - No REDIR, IMEM_BUSYWAIT or STALL: PC holds.
  - Otherwise: PC <= PC + 4. Wraps 0xFFFF_FFFC -> 0x0000_0000.
- S_PEND: IMEM_READ = 1; PC holds the old value until memory releases.
  - New REDIR: overwrite the pending target; FLUSH = 1.
  - IMEM_BUSYWAIT falls:
    - PC <= pending target (or the new REDIR target if REDIR is present in the same cycle).
    - FLUSH = 1, so the stale word returned by memory is squashed.
    - Go to S_RUN.
- FLUSH is 0 in all other cases. It is combinational from REDIR, state and IMEM_BUSYWAIT.
- MISALIGN is set on any accepted REDIR with BRANCH_TARGET[1:0] != 0. It clears only on RESET.
- REDIRECT_COUNT increments by 1 on every cycle with REDIR = 1 (outside S_BOOT) and saturates at all-ones.
- REDIR in S_BOOT is ignored: no FLUSH, no count.

## Timing
- Redirect latency: REDIR sampled at edge N gives PC = target after edge N.
- Branch penalty is 2 squashed instructions, carried by FLUSH in cycle N.
- STALL never delays a redirect: STALL and REDIR together in S_RUN give the redirect.
- A redirect held off by memory takes effect on the edge where IMEM_BUSYWAIT is sampled 0.
- Reset values:
  - PC = RESET_PC, PC_PLUS4 = RESET_PC + 4.
  - IMEM_READ = 0 in the first cycle after reset, then 1.
  - FLUSH = 0, MISALIGN = 0, REDIRECT_COUNT = 0.
- RESET asserted mid-S_PEND discards the pending target.

## Test plan
- Reset/sequential fetch:
  - Stimulus: RESET_PC = 0x100, RESET for 2 cycles.
  - Response: PC = 0x100 with IMEM_READ = 0 for one cycle, then PC 0x100, 0x104, 0x108; FLUSH = 0, count 0.
- Taken branch:
  - Stimulus: REDIR with target 0x200 while PC = 0x10C.
  - Response: FLUSH = 1 that cycle, next PC = 0x200, REDIRECT_COUNT = 1.
- Invalid request:
  - Stimulus: PC_SEL = 1 with EX_VALID = 0.
  - Response: PC increments, FLUSH = 0, count unchanged.
- Stall priority:
  - Stimulus: STALL high 3 cycles.
  - Response: PC held at 0x104 for all 3 cycles.
  - Stimulus: STALL and REDIR(0x300) together.
  - Response: PC = 0x300 next, FLUSH = 1.
- Memory wait:
  - Stimulus: IMEM_BUSYWAIT high 4 cycles; REDIR(0x400) in cycle 2, REDIR(0x500) in cycle 3.
  - Response: PC held; FLUSH = 1 in cycles 2, 3 and the release cycle; PC = 0x500 after release; count +2.
- Misaligned target and counter saturation:
  - Stimulus: REDIR with target 0x203.
  - Response: PC = 0x200, MISALIGN = 1 until the next RESET.
  - Stimulus: CNT_WIDTH = 4, 20 redirects.
  - Response: REDIRECT_COUNT = 0xF.
